// File: rtl/ram_mp_pkg.sv
// ram_mp_pkg: shared types and helpers for the multi-read-port register RAM.
//   ram_state_e   : flush engine state (StIdle, StFlush)
//   *_DEF         : default geometry of the FIX tag/field table instance
//   depth()       : entry count for a given index width
//   be_width()    : byte-enable count for a given entry width
//   byte_sel()    : single-byte write-first merge (new byte when enabled, else old)
package ram_mp_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } ram_state_e;

    localparam int unsigned DATA_WIDTH_DEF = 256;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned NUM_RD_DEF     = 2;

    function automatic int unsigned depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic logic [7:0] byte_sel(input logic       be,
                                            input logic [7:0] new_byte,
                                            input logic [7:0] old_byte);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_mp_rd_port.sv
// ram_mp_rd_port: one registered read port of ram_mp.
//   clk, rst          : clock, asynchronous active-low reset
//   idle_i            : RAM not flushing; reads are only accepted while high
//   rd_i, rd_index_i  : read request and entry index
//   mem_i, valid_i    : whole data array and valid vector from the top
//   wr_en_i, wr_*_i   : the write actually committed this cycle (for write-first bypass)
//   rd_valid_o        : response strobe, one cycle after an accepted read
//   rd_hit_o          : entry valid bit as seen by the read
//   rd_data_o         : entry data; holds its last value when no read is accepted
module ram_mp_rd_port
    import ram_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      idle_i,
    input  logic                      rd_i,
    input  logic [ADDR_WIDTH-1:0]     rd_index_i,
    input  logic [DATA_WIDTH-1:0]     mem_i [1 << ADDR_WIDTH],
    input  logic [(1<<ADDR_WIDTH)-1:0] valid_i,
    input  logic                      wr_en_i,
    input  logic [ADDR_WIDTH-1:0]     wr_index_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]   wr_be_i,
    output logic                      rd_valid_o,
    output logic                      rd_hit_o,
    output logic [DATA_WIDTH-1:0]     rd_data_o
);

    localparam int unsigned NUM_BYTES = be_width(DATA_WIDTH);

    logic                  accept;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] entry;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  hit_d;

    logic                  rd_valid_q;
    logic                  rd_hit_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    assign accept = rd_i & idle_i;
    assign entry  = mem_i[rd_index_i];
    // A same-cycle write to the same entry is visible to the read (write-first).
    assign bypass = wr_en_i && (wr_index_i == rd_index_i);

    always_comb begin
        data_d = entry;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (bypass) begin
                data_d[8*b +: 8] = byte_sel(wr_be_i[b], wr_data_i[8*b +: 8], entry[8*b +: 8]);
            end
        end
        hit_d = bypass | valid_i[rd_index_i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= accept;
            if (accept) begin
                rd_hit_q  <= hit_d;
                rd_data_q <= data_d;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_hit_o   = rd_hit_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/ram_mp.sv
// ram_mp: multi-read-port register RAM for the FIX parser tag/field tables.
//   clk, rst      : clock, asynchronous active-low reset
//   rd_i          : per-port read request (NUM_RD bits)
//   rd_index_i    : per-port index, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_i          : write request
//   wr_index_i    : write index
//   wr_data_i     : write data
//   wr_be_i       : byte enables, bit b covers wr_data_i[8b +: 8]
//   clr_i         : start a flush of all valid bits
//   busy_o        : flush in progress; reads, writes and clr_i are ignored meanwhile
//   rd_valid_o    : per-port response strobe, one cycle after an accepted read
//   rd_hit_o      : per-port entry valid bit at time of read
//   rd_data_o     : per-port read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
module ram_mp
    import ram_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_RD     = NUM_RD_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0]            rd_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_index_i,
    input  logic                         wr_i,
    input  logic [ADDR_WIDTH-1:0]        wr_index_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]      wr_be_i,
    input  logic                         clr_i,
    output logic                         busy_o,
    output logic [NUM_RD-1:0]            rd_valid_o,
    output logic [NUM_RD-1:0]            rd_hit_o,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned NUM_ENTRIES = depth(ADDR_WIDTH);
    localparam int unsigned NUM_BYTES   = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]  mem_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    ram_state_e             state_q;
    logic [ADDR_WIDTH-1:0]  cnt_q;
    logic                   busy_q;

    logic idle;
    logic wr_en;

    assign idle  = (state_q == StIdle);
    // clr_i takes priority: a write arriving with it is dropped.
    assign wr_en = idle & wr_i & ~clr_i;

    // Data array carries no reset; stale content is gated by the valid bits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_index_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Flush engine and valid vector. busy_q is high exactly while in StFlush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr_i) begin
                        state_q <= StFlush;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else if (wr_i) begin
                        // Valid even with no byte enabled.
                        valid_q[wr_index_i] <= 1'b1;
                    end
                end
                StFlush: begin
                    valid_q[cnt_q] <= 1'b0;
                    if (&cnt_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        ram_mp_rd_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_rd_port (
            .clk        (clk),
            .rst        (rst),
            .idle_i     (idle),
            .rd_i       (rd_i[p]),
            .rd_index_i (rd_index_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_i      (mem_q),
            .valid_i    (valid_q),
            .wr_en_i    (wr_en),
            .wr_index_i (wr_index_i),
            .wr_data_i  (wr_data_i),
            .wr_be_i    (wr_be_i),
            .rd_valid_o (rd_valid_o[p]),
            .rd_hit_o   (rd_hit_o[p]),
            .rd_data_o  (rd_data_o[p*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_ram_mp.sv
// tb_ram_mp: directed self-checking bench for ram_mp (256-bit entries, 32 deep, 2 read ports).
module tb_ram_mp;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    rd_i;
    logic [NR*AW-1:0] rd_index_i;
    logic             wr_i;
    logic [AW-1:0]    wr_index_i;
    logic [DW-1:0]    wr_data_i;
    logic [DW/8-1:0]  wr_be_i;
    logic             clr_i;
    logic             busy_o;
    logic [NR-1:0]    rd_valid_o;
    logic [NR-1:0]    rd_hit_o;
    logic [NR*DW-1:0] rd_data_o;

    int n_cmp;
    int n_err;
    int n;

    ram_mp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_RD    (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_i       (rd_i),
        .rd_index_i (rd_index_i),
        .wr_i       (wr_i),
        .wr_index_i (wr_index_i),
        .wr_data_i  (wr_data_i),
        .wr_be_i    (wr_be_i),
        .clr_i      (clr_i),
        .busy_o     (busy_o),
        .rd_valid_o (rd_valid_o),
        .rd_hit_o   (rd_hit_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fill_val(input int i);
        logic [7:0] b;
        b = 8'(8'h40 + i);
        return {32{b}};
    endfunction

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        clk        = 1'b0;
        rst        = 1'b0;
        rd_i       = '0;
        rd_index_i = '0;
        wr_i       = 1'b0;
        wr_index_i = '0;
        wr_data_i  = '0;
        wr_be_i    = '0;
        clr_i      = 1'b0;

        // Reset state
        #12;
        check("rst_busy",     512'(busy_o),     512'(0));
        check("rst_rd_valid", 512'(rd_valid_o), 512'(0));
        check("rst_rd_hit",   512'(rd_hit_o),   512'(0));
        check("rst_rd_data",  512'(rd_data_o),  512'(0));
        rst = 1'b1;

        // 1: read invalid entry 3 on port 0
        rd_i = 2'b01; rd_index_i = {5'd0, 5'd3};
        tick();
        rd_i = '0;
        check("t1_valid", 512'(rd_valid_o),  512'(2'b01));
        check("t1_hit0",  512'(rd_hit_o[0]), 512'(0));

        // 2: full write idx 5, read on both ports
        wr_i = 1'b1; wr_index_i = 5'd5; wr_data_i = rep(8'hA5); wr_be_i = '1;
        tick();
        wr_i = 1'b0;
        rd_i = 2'b11; rd_index_i = {5'd5, 5'd5};
        tick();
        rd_i = '0;
        check("t2_valid", 512'(rd_valid_o), 512'(2'b11));
        check("t2_hit",   512'(rd_hit_o),   512'(2'b11));
        check("t2_data",  rd_data_o,        {rep(8'hA5), rep(8'hA5)});

        // 3: write-first byte merge on port 1; port 0 idle holds its last response
        wr_i = 1'b1; wr_index_i = 5'd7; wr_data_i = '0; wr_be_i = '1;
        tick();
        wr_data_i = rep(8'hFF); wr_be_i = 32'h0000_000F;
        rd_i = 2'b10; rd_index_i = {5'd7, 5'd0};
        tick();
        wr_i = 1'b0; rd_i = '0;
        check("t3_valid",     512'(rd_valid_o),          512'(2'b10));
        check("t3_hit1",      512'(rd_hit_o[1]),         512'(1));
        check("t3_data1",     512'(rd_data_o[511:256]),  512'({224'h0, 32'hFFFF_FFFF}));
        check("t3_hold_hit0", 512'(rd_hit_o[0]),         512'(1));
        check("t3_hold_dat0", 512'(rd_data_o[255:0]),    512'(rep(8'hA5)));
        rd_i = 2'b01; rd_index_i = {5'd0, 5'd7};
        tick();
        rd_i = '0;
        check("t3_commit", 512'(rd_data_o[255:0]), 512'({224'h0, 32'hFFFF_FFFF}));

        // 4: fill every entry, flush; reads and writes during flush are ignored
        wr_i = 1'b1; wr_be_i = '1;
        for (int i = 0; i < 32; i++) begin
            wr_index_i = 5'(i); wr_data_i = fill_val(i);
            tick();
        end
        wr_i = 1'b0;
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        rd_i = 2'b11; rd_index_i = {5'd4, 5'd3};
        wr_i = 1'b1; wr_index_i = 5'd4; wr_data_i = rep(8'hDE);
        n = 0;
        while (busy_o && n < 100) begin
            check("t4_rd_ignored", 512'(rd_valid_o), 512'(0));
            tick();
            n++;
        end
        rd_i = '0; wr_i = 1'b0;
        check("t4_flush_len", 512'(n), 512'(32));
        for (int i = 0; i < 32; i++) begin
            rd_i = 2'b11; rd_index_i = {5'(31 - i), 5'(i)};
            tick();
            check("t4_hit",   512'(rd_hit_o),  512'(2'b00));
            check("t4_data",  rd_data_o,       {fill_val(31 - i), fill_val(i)});
        end
        rd_i = '0;

        // 5: clr with write idx 2 in the same cycle; the read in that cycle is served
        rd_i = 2'b01; rd_index_i = {5'd0, 5'd4};
        clr_i = 1'b1;
        wr_i = 1'b1; wr_index_i = 5'd2; wr_data_i = rep(8'h77);
        tick();
        wr_i = 1'b0; rd_i = '0;
        check("t5_rd_served", 512'(rd_valid_o),       512'(2'b01));
        check("t5_rd_data",   512'(rd_data_o[255:0]), 512'(fill_val(4)));
        check("t5_busy",      512'(busy_o),           512'(1));
        tick(); // clr_i still high here and must be ignored
        clr_i = 1'b0;
        n = 1;
        while (busy_o && n < 100) begin
            tick();
            n++;
        end
        check("t5_flush_len", 512'(n), 512'(32));
        rd_i = 2'b11; rd_index_i = {5'd4, 5'd2};
        tick();
        rd_i = '0;
        check("t5_hit",   512'(rd_hit_o),          512'(2'b00));
        check("t5_data0", 512'(rd_data_o[255:0]),  512'(fill_val(2)));

        // 6: reset in the middle of a flush
        wr_i = 1'b1; wr_be_i = '1;
        wr_index_i = 5'd25; wr_data_i = rep(8'h5A);
        tick();
        wr_index_i = 5'd9; wr_data_i = rep(8'h99);
        tick();
        wr_i = 1'b0;
        rd_i = 2'b10; rd_index_i = {5'd25, 5'd0};
        tick();
        rd_i = '0;
        check("t6_pre_hit", 512'(rd_hit_o[1]), 512'(1));
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        repeat (10) tick();
        check("t6_busy_mid", 512'(busy_o), 512'(1));
        rst = 1'b0;
        #1;
        check("t6_rst_busy",  512'(busy_o),     512'(0));
        check("t6_rst_valid", 512'(rd_valid_o), 512'(0));
        check("t6_rst_hit",   512'(rd_hit_o),   512'(0));
        check("t6_rst_data",  512'(rd_data_o),  512'(0));
        #1;
        rst = 1'b1;
        rd_i = 2'b11; rd_index_i = {5'd25, 5'd9};
        tick();
        rd_i = '0;
        check("t6_post_valid", 512'(rd_valid_o), 512'(2'b11));
        check("t6_post_hit",   512'(rd_hit_o),   512'(2'b00));
        check("t6_post_data",  rd_data_o,        {rep(8'h5A), rep(8'h99)});
        check("t6_post_busy",  512'(busy_o),     512'(0));
        wr_i = 1'b1; wr_index_i = 5'd25; wr_data_i = rep(8'hC3); wr_be_i = '1;
        tick();
        wr_i = 1'b0;
        rd_i = 2'b01; rd_index_i = {5'd0, 5'd25};
        tick();
        rd_i = '0;
        check("t6_new_hit",  512'(rd_hit_o[0]),       512'(1));
        check("t6_new_data", 512'(rd_data_o[255:0]),  512'(rep(8'hC3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
